// File: rtl/riscv_fetch_buffer.sv
// Instruction-fetch front end: PC generation, icache request issue and a DEPTH-entry prefetch FIFO.
// Optional JAL predecode in fetch is enabled by defining FETCH_JAL_PREDECODE_EN.
module riscv_fetch_buffer #(
    parameter int unsigned        DWIDTH   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [DWIDTH-1:0]  PC_RESET = DWIDTH'(32'h0000_2000)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    output logic [DWIDTH-1:0]            icache_addr,
    output logic                         icache_re,
    input  logic [DWIDTH-1:0]            icache_dout,
    input  logic                         redirect_valid,
    input  logic [DWIDTH-1:0]            redirect_pc,
    output logic                         id_valid,
    output logic [DWIDTH-1:0]            id_instr,
    output logic [DWIDTH-1:0]            id_pc,
    output logic                         id_pred_taken,
    input  logic                         id_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned       AW  = $clog2(DEPTH);
    localparam int unsigned       CW  = $clog2(DEPTH+1);
    localparam logic [DWIDTH-1:0] NOP = DWIDTH'(32'h0000_0013);

    logic [DWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DWIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DWIDTH-1:0] instr_mem_q [DEPTH];
    logic [DWIDTH-1:0] pc_mem_q    [DEPTH];

    logic              pop;
    logic              redir;
    logic              push;
    logic              issue;
    logic              jal_hit;
    logic [CW:0]       level;

    assign redir = redirect_valid & ~stall;
    assign pop   = (count_q != '0) & id_ready & ~stall;
    assign push  = inflight_q & ~stall & ~redir;

`ifdef FETCH_JAL_PREDECODE_EN
    logic              pred_mem_q [DEPTH];
    logic [DWIDTH-1:0] jal_imm;

    assign jal_hit = push & (icache_dout[6:0] == 7'b1101111);
    assign jal_imm = {{(DWIDTH-21){icache_dout[31]}}, icache_dout[31], icache_dout[19:12],
                      icache_dout[20], icache_dout[30:21], 1'b0};
`else
    assign jal_hit = 1'b0;
`endif

    // Slots already committed: held entries plus the response landing now, less the entry leaving now.
    assign level     = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue     = ~stall & ~redirect_valid & ~jal_hit & (level < (CW+1)'(DEPTH));
    assign icache_re = issue;

    assign icache_addr = fetch_pc_q;
    assign occupancy   = count_q;

    always_comb begin
        id_valid      = (count_q != '0);
        id_instr      = NOP;
        id_pc         = '0;
        id_pred_taken = 1'b0;
        if (id_valid) begin
            id_instr = instr_mem_q[rd_ptr_q];
            id_pc    = pc_mem_q[rd_ptr_q];
`ifdef FETCH_JAL_PREDECODE_EN
            id_pred_taken = pred_mem_q[rd_ptr_q];
`endif
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redir) begin
            fetch_pc_d = redirect_pc & ~DWIDTH'(3);
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = issue | (inflight_q & ~push);
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + DWIDTH'(4);
            end
`ifdef FETCH_JAL_PREDECODE_EN
            if (jal_hit) fetch_pc_d = inflight_pc_q + jal_imm;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= PC_RESET;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
`ifdef FETCH_JAL_PREDECODE_EN
                pred_mem_q[i]  <= 1'b0;
`endif
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= icache_dout;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
`ifdef FETCH_JAL_PREDECODE_EN
            pred_mem_q[wr_ptr_q]  <= jal_hit;
`endif
        end
    end

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Self-checking bench for riscv_fetch_buffer: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_riscv_fetch_buffer;

    localparam int unsigned DEPTH = 4;
`ifdef FETCH_JAL_PREDECODE_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic        id_ready = 1'b0;
    logic [2:0]  occupancy;

    riscv_fetch_buffer #(
        .DWIDTH  (32),
        .DEPTH   (DEPTH),
        .PC_RESET(32'h0000_2000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .icache_addr   (icache_addr),
        .icache_re     (icache_re),
        .icache_dout   (icache_dout),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pred_taken (id_pred_taken),
        .id_ready      (id_ready),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    bit jal_on = 1'b0;

    // Instruction memory: each word holds its own address, except a JAL (+0x100) at 0x2008 when enabled.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (jal_on && a == 32'h0000_2008) return 32'h1000_006F;
        return a;
    endfunction

    function automatic logic [31:0] jimm(input logic [31:0] ins);
        logic [20:0] j;
        j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return {{11{j[20]}}, j};
    endfunction

    always @(posedge clk) if (icache_re) icache_dout <= mem(icache_addr);

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          pred;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pc;
    bit          s_stall, s_rv, s_pop, s_re, s_jal;
    logic [31:0] s_rpc;

    task automatic model_reset();
        mq.delete();
        m_pend = 1'b0;
        m_pend_pc = '0;
        m_pc = 32'h0000_2000;
    endtask

    task automatic mcheck();
        bit          hv, hpr, push;
        logic [31:0] hp, hn, ins;
        int          lvl;
        hv = (mq.size() > 0);
        hp = '0; hpr = 1'b0; hn = 32'h0000_0013;
        if (hv) begin
            hp  = mq[0].pc;
            hpr = mq[0].pred;
            hn  = mem(hp);
        end
        s_stall = stall; s_rv = redirect_valid; s_rpc = redirect_pc;
        s_pop = hv && id_ready && !stall;
        push  = m_pend && !stall && !redirect_valid;
        s_jal = 1'b0;
        if (PRED && push) begin
            ins = mem(m_pend_pc);
            s_jal = (ins[6:0] == 7'b1101111);
        end
        lvl  = mq.size() + int'(m_pend) - int'(s_pop);
        s_re = !stall && !redirect_valid && !s_jal && (lvl < DEPTH);
        chk("m.icache_re", {31'b0, icache_re}, {31'b0, s_re});
        chk("m.icache_addr", icache_addr, m_pc);
        chk("m.id_valid", {31'b0, id_valid}, {31'b0, hv});
        chk("m.id_pc", id_pc, hp);
        chk("m.id_instr", id_instr, hn);
        chk("m.id_pred_taken", {31'b0, id_pred_taken}, {31'b0, hpr});
        chk("m.occupancy", {29'b0, occupancy}, mq.size());
    endtask

    task automatic model_step();
        ent_t e;
        if (s_stall) return;
        if (s_rv) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc = s_rpc & ~32'd3;
            return;
        end
        if (s_pop) void'(mq.pop_front());
        if (m_pend) begin
            e.pc = m_pend_pc;
            e.pred = s_jal;
            mq.push_back(e);
        end
        if (s_jal) m_pc = m_pend_pc + jimm(mem(m_pend_pc));
        m_pend = s_re;
        if (s_re) begin
            m_pend_pc = m_pc;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic begin_cycle(input bit st, input bit rdy, input bit rv, input logic [31:0] rpc);
        stall = st; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        @(negedge clk);
        mcheck();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic run(input int n, input bit st, input bit rdy);
        for (int i = 0; i < n; i++) begin
            begin_cycle(st, rdy, 1'b0, '0);
            end_cycle();
        end
    endtask

    typedef struct {
        bit          st;
        bit          rdy;
        bit          re;
        logic [31:0] addr;
        bit          v;
        logic [31:0] pc;
        int          occ;
    } vec_t;

    vec_t tab[12];

    initial begin
        logic [31:0] snap_pc, snap_addr;
        logic [2:0]  snap_occ;
        logic [31:0] pops[$];
        logic [31:0] exp_pops[4];
        bit          pred_at_2008;
        bit          st, rdy, rv;
        logic [31:0] rpc;

        tab[0]  = '{0, 1, 1, 32'h2000, 0, 32'h0000, 0};
        tab[1]  = '{0, 1, 1, 32'h2004, 0, 32'h0000, 0};
        tab[2]  = '{0, 1, 1, 32'h2008, 1, 32'h2000, 1};
        tab[3]  = '{0, 1, 1, 32'h200C, 1, 32'h2004, 1};
        tab[4]  = '{0, 1, 1, 32'h2010, 1, 32'h2008, 1};
        tab[5]  = '{0, 1, 1, 32'h2014, 1, 32'h200C, 1};
        tab[6]  = '{0, 0, 1, 32'h2018, 1, 32'h2010, 1};
        tab[7]  = '{0, 0, 1, 32'h201C, 1, 32'h2010, 2};
        tab[8]  = '{0, 0, 0, 32'h2020, 1, 32'h2010, 3};
        tab[9]  = '{0, 0, 0, 32'h2020, 1, 32'h2010, 4};
        tab[10] = '{0, 1, 1, 32'h2020, 1, 32'h2010, 4};
        tab[11] = '{1, 1, 0, 32'h2024, 1, 32'h2014, 3};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.occupancy", {29'b0, occupancy}, 32'd0);
        chk("rst.id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst.id_instr", id_instr, 32'h0000_0013);
        chk("rst.id_pc", id_pc, 32'd0);
        chk("rst.icache_addr", icache_addr, 32'h0000_2000);
        chk("rst.id_pred_taken", {31'b0, id_pred_taken}, 32'd0);
        chk("rst.icache_re", {31'b0, icache_re}, 32'd1);
        reset = 1'b0;

        // Directed stream, saturation and stall table
        for (int i = 0; i < 12; i++) begin
            begin_cycle(tab[i].st, tab[i].rdy, 1'b0, '0);
            chk($sformatf("tab%0d.icache_re", i), {31'b0, icache_re}, {31'b0, tab[i].re});
            chk($sformatf("tab%0d.icache_addr", i), icache_addr, tab[i].addr);
            chk($sformatf("tab%0d.id_valid", i), {31'b0, id_valid}, {31'b0, tab[i].v});
            chk($sformatf("tab%0d.id_pc", i), id_pc, tab[i].pc);
            chk($sformatf("tab%0d.occupancy", i), {29'b0, occupancy}, tab[i].occ);
            end_cycle();
        end

        // Redirect to 0x3003 with three entries queued and one response in flight
        begin_cycle(1'b0, 1'b0, 1'b1, 32'h0000_3003);
        chk("redir.r.occupancy", {29'b0, occupancy}, 32'd3);
        end_cycle();
        begin_cycle(1'b0, 1'b1, 1'b0, '0);
        chk("redir.r1.icache_addr", icache_addr, 32'h0000_3000);
        chk("redir.r1.icache_re", {31'b0, icache_re}, 32'd1);
        chk("redir.r1.occupancy", {29'b0, occupancy}, 32'd0);
        end_cycle();
        begin_cycle(1'b0, 1'b1, 1'b0, '0);
        chk("redir.r2.id_valid", {31'b0, id_valid}, 32'd0);
        end_cycle();
        begin_cycle(1'b0, 1'b1, 1'b0, '0);
        chk("redir.r3.id_valid", {31'b0, id_valid}, 32'd1);
        chk("redir.r3.id_pc", id_pc, 32'h0000_3000);
        end_cycle();
        begin_cycle(1'b0, 1'b1, 1'b0, '0);
        chk("redir.r4.id_pc", id_pc, 32'h0000_3004);
        end_cycle();

        // Five-cycle stall mid-stream with a response pending
        run(3, 1'b0, 1'b1);
        begin_cycle(1'b1, 1'b1, 1'b0, '0);
        snap_pc = id_pc; snap_addr = icache_addr; snap_occ = occupancy;
        end_cycle();
        for (int i = 0; i < 4; i++) begin
            begin_cycle(1'b1, 1'b1, 1'b0, '0);
            chk("stall.id_pc", id_pc, snap_pc);
            chk("stall.icache_addr", icache_addr, snap_addr);
            chk("stall.occupancy", {29'b0, occupancy}, {29'b0, snap_occ});
            chk("stall.icache_re", {31'b0, icache_re}, 32'd0);
            end_cycle();
        end
        run(4, 1'b0, 1'b1);

        // Redirect and pop together with the FIFO full: the flush wins
        run(6, 1'b0, 1'b0);
        begin_cycle(1'b0, 1'b1, 1'b1, 32'h0000_4000);
        chk("fullredir.occupancy", {29'b0, occupancy}, 32'd4);
        end_cycle();
        begin_cycle(1'b0, 1'b1, 1'b0, '0);
        chk("fullredir.next.occupancy", {29'b0, occupancy}, 32'd0);
        chk("fullredir.next.id_valid", {31'b0, id_valid}, 32'd0);
        end_cycle();

        // Asynchronous reset mid-stream clears state without waiting for a clock edge
        run(5, 1'b0, 1'b0);
        stall = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("areset.occupancy", {29'b0, occupancy}, 32'd0);
        chk("areset.id_valid", {31'b0, id_valid}, 32'd0);
        chk("areset.icache_addr", icache_addr, 32'h0000_2000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        jal_on = 1'b1;

        // JAL at 0x2008: predecode jumps straight to 0x2108, otherwise it flows sequentially
        for (int i = 0; i < 10; i++) begin
            begin_cycle(1'b0, 1'b1, 1'b0, '0);
            if (id_valid) begin
                pops.push_back(id_pc);
                if (id_pc == 32'h0000_2008) pred_at_2008 = id_pred_taken;
            end
            end_cycle();
        end
        exp_pops[0] = 32'h2000; exp_pops[1] = 32'h2004; exp_pops[2] = 32'h2008;
        exp_pops[3] = PRED ? 32'h2108 : 32'h200C;
        chk("jal.pop_count_ge4", {31'b0, pops.size() >= 4}, 32'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("jal.pop%0d", i), (i < pops.size()) ? pops[i] : 32'hFFFF_FFFF, exp_pops[i]);
        chk("jal.pred_taken", {31'b0, pred_at_2008}, {31'b0, PRED});

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 9) < 2);
            rdy = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'h0000_2000 | $urandom_range(0, 31);
                1:       rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: rpc = $urandom;
            endcase
            begin_cycle(st, rdy, rv, rpc);
            end_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
